// File: rtl/bus_arbiter.sv
// Two-requester arbiter for the SRAM adapter port; zero-cycle command path, read IDs queued for return routing.
// Optional alternation between requesters with BUS_ARB_ROUND_ROBIN_EN; default is fixed priority to requester 0.
module bus_arbiter #(
    parameter int MAX_PENDING = 4,
    parameter int ADDR_W      = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] req0_address,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [31:0]       req0_writedata,
    output logic              req0_waitrequest,
    output logic [31:0]       req0_readdata,
    output logic              req0_readdatavalid,
    input  logic [ADDR_W-1:0] req1_address,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [31:0]       req1_writedata,
    output logic              req1_waitrequest,
    output logic [31:0]       req1_readdata,
    output logic              req1_readdatavalid,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic              master_write,
    output logic [31:0]       master_writedata,
    input  logic [31:0]       master_readdata,
    input  logic              master_readdatavalid,
    input  logic              master_waitrequest,
    output logic              err_orphan
);

    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic             gnt_q, gnt_d;
    logic             locked_q, locked_d;
    logic             last_q, last_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             id_mem_q [MAX_PENDING];
    logic             id_mem_d [MAX_PENDING];
    logic             err_orphan_q, err_orphan_d;

    logic full, elig0, elig1, win, win_elig, fwd_rd, fwd_wr;
    logic accept, push, pop, rd_id;

    // Full comes from the registered count so a same-cycle pop never admits a read.
    assign full  = (count_q == CNT_W'(MAX_PENDING));
    assign elig0 = req0_write | (req0_read & ~full);
    assign elig1 = req1_write | (req1_read & ~full);

    always_comb begin
        win = 1'b0;
        if (locked_q) begin
            win = gnt_q;
        end else if (elig0 && elig1) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
            win = ~last_q;
`else
            win = 1'b0;
`endif
        end else if (elig1) begin
            win = 1'b1;
        end
    end

    assign win_elig = win ? elig1 : elig0;
    assign fwd_rd   = win_elig & (win ? req1_read : req0_read);
    assign fwd_wr   = win_elig & (win ? req1_write : req0_write);

    assign master_address   = win ? req1_address : req0_address;
    assign master_writedata = win ? req1_writedata : req0_writedata;
    assign master_read      = fwd_rd;
    assign master_write     = fwd_wr;

    assign req0_waitrequest = (!win && win_elig) ? master_waitrequest : 1'b1;
    assign req1_waitrequest = ( win && win_elig) ? master_waitrequest : 1'b1;

    assign accept = (fwd_rd | fwd_wr) & ~master_waitrequest;
    assign push   = accept & fwd_rd;
    assign pop    = master_readdatavalid & (count_q != '0);
    assign rd_id  = id_mem_q[rd_ptr_q];

    assign req0_readdata      = master_readdata;
    assign req1_readdata      = master_readdata;
    assign req0_readdatavalid = pop & ~rd_id;
    assign req1_readdatavalid = pop & rd_id;
    assign err_orphan         = err_orphan_q;

    always_comb begin
        gnt_d        = gnt_q;
        locked_d     = locked_q;
        last_d       = last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        id_mem_d     = id_mem_q;
        err_orphan_d = err_orphan_q;

        if ((fwd_rd | fwd_wr) && master_waitrequest) begin
            locked_d = 1'b1;
            gnt_d    = win;
        end
        if (accept) begin
            locked_d = 1'b0;
            last_d   = win;
        end
        if (push) begin
            id_mem_d[wr_ptr_q] = win;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (master_readdatavalid && count_q == '0) begin
            err_orphan_d = 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_q        <= 1'b0;
            locked_q     <= 1'b0;
            last_q       <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
            for (int i = 0; i < MAX_PENDING; i++) begin
                id_mem_q[i] <= 1'b0;
            end
        end else begin
            gnt_q        <= gnt_d;
            locked_q     <= locked_d;
            last_q       <= last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
            id_mem_q     <= id_mem_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; expectations adapt to the BUS_ARB_ROUND_ROBIN_EN build.
module tb_bus_arbiter;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [25:0] req0_address, req1_address, master_address;
    logic        req0_read, req0_write, req1_read, req1_write;
    logic [31:0] req0_writedata, req1_writedata, master_writedata;
    logic        req0_waitrequest, req1_waitrequest;
    logic [31:0] req0_readdata, req1_readdata, master_readdata;
    logic        req0_readdatavalid, req1_readdatavalid;
    logic        master_read, master_write, master_readdatavalid, master_waitrequest;
    logic        err_orphan;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    bus_arbiter #(.MAX_PENDING(4), .ADDR_W(26)) dut (
        .clock(clock), .reset(reset),
        .req0_address(req0_address), .req0_read(req0_read), .req0_write(req0_write),
        .req0_writedata(req0_writedata), .req0_waitrequest(req0_waitrequest),
        .req0_readdata(req0_readdata), .req0_readdatavalid(req0_readdatavalid),
        .req1_address(req1_address), .req1_read(req1_read), .req1_write(req1_write),
        .req1_writedata(req1_writedata), .req1_waitrequest(req1_waitrequest),
        .req1_readdata(req1_readdata), .req1_readdatavalid(req1_readdatavalid),
        .master_address(master_address), .master_read(master_read), .master_write(master_write),
        .master_writedata(master_writedata), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid), .master_waitrequest(master_waitrequest),
        .err_orphan(err_orphan)
    );

    task automatic idle_inputs();
        req0_address = '0; req0_read = 0; req0_write = 0; req0_writedata = '0;
        req1_address = '0; req1_read = 0; req1_write = 0; req1_writedata = '0;
        master_readdata = '0; master_readdatavalid = 0; master_waitrequest = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        #12;
        n_checks++;
        if (master_read !== 1'b0 || master_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_cmd: rd=%b wr=%b, required 0 0", master_read, master_write);
        end
        n_checks++;
        if (req0_readdatavalid !== 1'b0 || req1_readdatavalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rdv: %b %b, required 0 0", req0_readdatavalid, req1_readdatavalid);
        end
        n_checks++;
        if (err_orphan !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: %b, required 0", err_orphan);
        end
        @(negedge clock);
        reset = 1;
        #1;
        n_checks++;
        if (req0_waitrequest !== 1'b1 || req1_waitrequest !== 1'b1) begin
            n_fail++; $display("FAIL reset_wait: %b %b, required 1 1", req0_waitrequest, req1_waitrequest);
        end
    endtask

    task automatic test_read_stall();
        @(negedge clock);
        req0_read = 1; req0_address = 26'h0000100; master_waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (req0_waitrequest !== 1'b1 || master_read !== 1'b1 || master_address !== 26'h0000100) begin
                n_fail++; $display("FAIL stall_%0d: wait=%b rd=%b addr=%h, required 1 1 0000100",
                                   i, req0_waitrequest, master_read, master_address);
            end
            @(negedge clock);
        end
        master_waitrequest = 0;
        #1;
        n_checks++;
        if (req0_waitrequest !== 1'b0) begin
            n_fail++; $display("FAIL stall_accept: wait=%b, required 0", req0_waitrequest);
        end
        @(negedge clock);
        req0_read = 0; master_readdatavalid = 1; master_readdata = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (req0_readdatavalid !== 1'b1 || req1_readdatavalid !== 1'b0 || req0_readdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL stall_return: rdv0=%b rdv1=%b data=%h, required 1 0 deadbeef",
                               req0_readdatavalid, req1_readdatavalid, req0_readdata);
        end
        @(negedge clock);
        master_readdatavalid = 0;
    endtask

    task automatic test_lock();
        @(negedge clock);
        req1_write = 1; req1_address = 26'h0000200; req1_writedata = 32'h12345678; master_waitrequest = 1;
        #1;
        n_checks++;
        if (master_write !== 1'b1 || master_address !== 26'h0000200 || req1_waitrequest !== 1'b1) begin
            n_fail++; $display("FAIL lock_first: wr=%b addr=%h wait1=%b, required 1 0000200 1",
                               master_write, master_address, req1_waitrequest);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            req0_read = 1; req0_address = 26'h0000300;
            #1;
            n_checks++;
            if (master_address !== 26'h0000200 || master_writedata !== 32'h12345678 ||
                master_read !== 1'b0 || req0_waitrequest !== 1'b1) begin
                n_fail++; $display("FAIL lock_hold_%0d: addr=%h data=%h rd=%b wait0=%b, required 0000200 12345678 0 1",
                                   i, master_address, master_writedata, master_read, req0_waitrequest);
            end
        end
        @(negedge clock);
        master_waitrequest = 0;
        #1;
        n_checks++;
        if (req1_waitrequest !== 1'b0 || req0_waitrequest !== 1'b1) begin
            n_fail++; $display("FAIL lock_accept1: wait1=%b wait0=%b, required 0 1", req1_waitrequest, req0_waitrequest);
        end
        @(negedge clock);
        req1_write = 0;
        #1;
        n_checks++;
        if (master_read !== 1'b1 || master_address !== 26'h0000300 || req0_waitrequest !== 1'b0) begin
            n_fail++; $display("FAIL lock_next0: rd=%b addr=%h wait0=%b, required 1 0000300 0",
                               master_read, master_address, req0_waitrequest);
        end
        @(negedge clock);
        req0_read = 0; master_readdatavalid = 1;
        #1;
        n_checks++;
        if (req0_readdatavalid !== 1'b1 || req1_readdatavalid !== 1'b0) begin
            n_fail++; $display("FAIL lock_return: rdv0=%b rdv1=%b, required 1 0", req0_readdatavalid, req1_readdatavalid);
        end
        @(negedge clock);
        master_readdatavalid = 0;
    endtask

    // Last accept so far was requester 0, so alternation starts with requester 1.
    task automatic test_back_to_back();
        bit exp_q[$];
        bit exp_win;
        bit id;
        @(negedge clock);
        req0_read = 1; req0_address = 26'h0000A00;
        req1_read = 1; req1_address = 26'h0000B00;
        master_waitrequest = 0;
        for (int i = 0; i < 4; i++) begin
            exp_win = RR ? ((i % 2) == 0) : 1'b0;
            #1;
            n_checks++;
            if (master_address !== (exp_win ? 26'h0000B00 : 26'h0000A00) ||
                req0_waitrequest !== exp_win || req1_waitrequest !== !exp_win) begin
                n_fail++; $display("FAIL b2b_win_%0d: addr=%h wait0=%b wait1=%b, required winner %0d",
                                   i, master_address, req0_waitrequest, req1_waitrequest, exp_win);
            end
            exp_q.push_back(exp_win);
            @(negedge clock);
        end
        req0_read = 0; req1_read = 0;
        for (int i = 0; i < 4; i++) begin
            master_readdatavalid = 1; master_readdata = 32'hC0DE0000 + i;
            id = exp_q.pop_front();
            #1;
            n_checks++;
            if (req0_readdatavalid !== !id || req1_readdatavalid !== id || req1_readdata !== 32'hC0DE0000 + i) begin
                n_fail++; $display("FAIL b2b_ret_%0d: rdv0=%b rdv1=%b data=%h, required id %0d",
                                   i, req0_readdatavalid, req1_readdatavalid, req1_readdata, id);
            end
            @(negedge clock);
        end
        master_readdatavalid = 0;
    endtask

    task automatic test_full();
        @(negedge clock);
        req0_read = 1; req0_address = 26'h0000040; master_waitrequest = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (req0_waitrequest !== 1'b0) begin
                n_fail++; $display("FAIL full_fill_%0d: wait0=%b, required 0", i, req0_waitrequest);
            end
            @(negedge clock);
        end
        req1_write = 1; req1_address = 26'h0000050;
        #1;
        n_checks++;
        if (req0_waitrequest !== 1'b1 || master_write !== 1'b1 || master_read !== 1'b0 || req1_waitrequest !== 1'b0) begin
            n_fail++; $display("FAIL full_write: wait0=%b wr=%b rd=%b wait1=%b, required 1 1 0 0",
                               req0_waitrequest, master_write, master_read, req1_waitrequest);
        end
        @(negedge clock);
        req1_write = 0; master_readdatavalid = 1;
        #1;
        n_checks++;
        if (req0_readdatavalid !== 1'b1 || req0_waitrequest !== 1'b1 || master_read !== 1'b0) begin
            n_fail++; $display("FAIL full_pop: rdv0=%b wait0=%b rd=%b, required 1 1 0",
                               req0_readdatavalid, req0_waitrequest, master_read);
        end
        @(negedge clock);
        master_readdatavalid = 0;
        #1;
        n_checks++;
        if (req0_waitrequest !== 1'b0 || master_read !== 1'b1) begin
            n_fail++; $display("FAIL full_release: wait0=%b rd=%b, required 0 1", req0_waitrequest, master_read);
        end
        @(negedge clock);
        req0_read = 0;
        for (int i = 0; i < 4; i++) begin
            master_readdatavalid = 1;
            #1;
            n_checks++;
            if (req0_readdatavalid !== 1'b1 || req1_readdatavalid !== 1'b0) begin
                n_fail++; $display("FAIL full_drain_%0d: rdv0=%b rdv1=%b, required 1 0",
                                   i, req0_readdatavalid, req1_readdatavalid);
            end
            @(negedge clock);
        end
        master_readdatavalid = 0;
        #1;
        n_checks++;
        if (err_orphan !== 1'b0) begin
            n_fail++; $display("FAIL full_no_orphan: err=%b, required 0", err_orphan);
        end
    endtask

    task automatic test_orphan();
        @(negedge clock);
        master_readdatavalid = 1;
        #1;
        n_checks++;
        if (req0_readdatavalid !== 1'b0 || req1_readdatavalid !== 1'b0) begin
            n_fail++; $display("FAIL orphan_rdv: %b %b, required 0 0", req0_readdatavalid, req1_readdatavalid);
        end
        @(negedge clock);
        master_readdatavalid = 0;
        #1;
        n_checks++;
        if (err_orphan !== 1'b1) begin
            n_fail++; $display("FAIL orphan_set: err=%b, required 1", err_orphan);
        end
        repeat (3) @(negedge clock);
        #1;
        n_checks++;
        if (err_orphan !== 1'b1) begin
            n_fail++; $display("FAIL orphan_sticky: err=%b, required 1", err_orphan);
        end
    endtask

    task automatic test_reset_pending();
        @(negedge clock);
        req0_read = 1; req0_address = 26'h0000070; master_waitrequest = 0;
        repeat (2) @(negedge clock);
        req0_read = 0;
        #2;
        reset = 0;
        #1;
        n_checks++;
        if (err_orphan !== 1'b0) begin
            n_fail++; $display("FAIL rst_err_clear: err=%b, required 0", err_orphan);
        end
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        master_readdatavalid = 1;
        #1;
        n_checks++;
        if (req0_readdatavalid !== 1'b0 || req1_readdatavalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_discard: rdv0=%b rdv1=%b, required 0 0", req0_readdatavalid, req1_readdatavalid);
        end
        @(negedge clock);
        master_readdatavalid = 0;
        #1;
        n_checks++;
        if (err_orphan !== 1'b1) begin
            n_fail++; $display("FAIL rst_late_orphan: err=%b, required 1", err_orphan);
        end
    endtask

    initial begin
        test_reset();
        test_read_stall();
        test_lock();
        test_back_to_back();
        test_full();
        test_orphan();
        test_reset_pending();
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
